// File: rtl/ram_responder.sv
// MFA/MFC slave with a byte-addressable big-endian RAM and programmable wait states.
// Define RAM_ALIGN_CHECK_EN to flag misaligned halfword/word accesses with MERR.
module ram_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              MFA,
    input  logic              RW_RAM,
    input  logic [1:0]        TYPE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       DATA_IN,
    output logic [31:0]       DATA_OUT,
    output logic              MFC,
    output logic              MERR
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned CntW  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    logic [7:0] Mem [0:Depth-1];

    state_e            r_state;
    logic [CntW-1:0]   r_cnt;
    logic              r_rw;
    logic [1:0]        r_type;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_dout;
    logic              r_merr;

    state_e            w_state_nxt;
    logic [CntW-1:0]   w_cnt_nxt;
    logic              w_access;
    logic              w_err;
    logic              w_we;
    logic [ADDR_W-1:0] w_lane_addr [4];
    logic [7:0]        w_rbyte [4];
    logic [31:0]       w_rdata;
    logic [31:0]       w_wdata_al;
    logic [3:0]        w_lane_en;

    // Lane k addresses byte A+k (wrapping); lane 0 is the most significant byte.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_lane_addr[k] = r_addr + ADDR_W'(k);
            w_rbyte[k]     = Mem[w_lane_addr[k]];
        end
    end

    always_comb begin
        w_rdata    = 32'h0;
        w_wdata_al = 32'h0;
        w_lane_en  = 4'b0000;
        case (r_type)
            2'b00: begin
                w_rdata    = {24'h0, w_rbyte[0]};
                w_wdata_al = {r_wdata[7:0], 24'h0};
                w_lane_en  = 4'b0001;
            end
            2'b01: begin
                w_rdata    = {16'h0, w_rbyte[0], w_rbyte[1]};
                w_wdata_al = {r_wdata[15:0], 16'h0};
                w_lane_en  = 4'b0011;
            end
            2'b10: begin
                w_rdata    = {w_rbyte[0], w_rbyte[1], w_rbyte[2], w_rbyte[3]};
                w_wdata_al = r_wdata;
                w_lane_en  = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_err = (r_type == 2'b11);
`ifdef RAM_ALIGN_CHECK_EN
        if ((r_type == 2'b01) && r_addr[0]) w_err = 1'b1;
        if ((r_type == 2'b10) && (r_addr[1:0] != 2'b00)) w_err = 1'b1;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_access    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (MFA) begin
                    w_state_nxt = StWait;
                    w_cnt_nxt   = CntW'(WAIT_STATES);
                end
            end
            StWait: begin
                if (!MFA) begin
                    w_state_nxt = StIdle;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end else begin
                    w_state_nxt = StDone;
                    w_access    = 1'b1;
                end
            end
            StDone: begin
                if (!MFA) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Reset keeps the FSM in StIdle, so a reset mid-transaction can never assert w_we.
    assign w_we = w_access && !r_rw && !w_err;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_rw    <= 1'b0;
            r_type  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_dout  <= 32'h0;
            r_merr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if ((r_state == StIdle) && MFA) begin
                r_rw    <= RW_RAM;
                r_type  <= TYPE;
                r_addr  <= ADDR;
                r_wdata <= DATA_IN;
                r_merr  <= 1'b0;
            end
            if (w_access) begin
                r_merr <= w_err;
                if (w_err) begin
                    r_dout <= 32'h0;
                end else if (r_rw) begin
                    r_dout <= w_rdata;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_lane_en[k]) Mem[w_lane_addr[k]] <= w_wdata_al[31-8*k -: 8];
            end
        end
    end

    assign MFC      = (r_state == StDone);
    assign MERR     = r_merr;
    assign DATA_OUT = r_dout;

endmodule

// File: tb/tb_ram_responder.sv
// Directed self-checking bench for ram_responder (default WAIT_STATES=2, ADDR_W=8).
module tb_ram_responder;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        mfa = 1'b0;
    logic        rw_ram = 1'b1;
    logic [1:0]  typ = 2'b00;
    logic [7:0]  addr = 8'h00;
    logic [31:0] data_in = 32'h0;
    logic [31:0] data_out;
    logic        mfc;
    logic        merr;

    int n_tests = 0;
    int n_fail  = 0;

    ram_responder #(.ADDR_W(8), .WAIT_STATES(WS)) dut (
        .CLK      (clk),
        .CLR      (clr),
        .MFA      (mfa),
        .RW_RAM   (rw_ram),
        .TYPE     (typ),
        .ADDR     (addr),
        .DATA_IN  (data_in),
        .DATA_OUT (data_out),
        .MFC      (mfc),
        .MERR     (merr)
    );

    always #5 clk = ~clk;

    // Full transaction; request fields are scrambled right after accept.
    task automatic xact(input logic rw, input logic [1:0] ty, input logic [7:0] a,
                        input logic [31:0] d, output logic [31:0] dout, output logic me,
                        output int lat);
        @(negedge clk);
        mfa = 1'b1; rw_ram = rw; typ = ty; addr = a; data_in = d;
        lat = -1; dout = 32'hxxxxxxxx; me = 1'bx;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                rw_ram = ~rw; typ = ~ty; addr = ~a; data_in = ~d;
            end
            if (mfc) begin
                lat = i; dout = data_out; me = merr;
                break;
            end
        end
        @(negedge clk); mfa = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({mfc, merr, data_out} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset: mfc=%b merr=%b dout=%h, want 0 0 0", mfc, merr, data_out);
        end
        @(negedge clk); clr = 1'b1;
    endtask

    task automatic test_word_read();
        logic exp;
        @(negedge clk);
        dut.Mem[0] = 8'hE3; dut.Mem[1] = 8'hA0; dut.Mem[2] = 8'h10; dut.Mem[3] = 8'h05;
        mfa = 1'b1; rw_ram = 1'b1; typ = 2'b10; addr = 8'h00;
        for (int i = 0; i < WS + 2; i++) begin
            @(posedge clk); #1;
            exp = (i == WS + 1);
            n_tests++;
            if (mfc !== exp) begin
                n_fail++;
                $display("FAIL word_read_lat edge e%0d: mfc=%b want %b", i, mfc, exp);
            end
        end
        n_tests++;
        if (data_out !== 32'hE3A01005 || merr !== 1'b0) begin
            n_fail++;
            $display("FAIL word_read_data: dout=%h merr=%b want E3A01005 0", data_out, merr);
        end
        @(negedge clk); mfa = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (mfc !== 1'b0 || data_out !== 32'hE3A01005) begin
            n_fail++;
            $display("FAIL word_read_drop: mfc=%b dout=%h want 0 E3A01005", mfc, data_out);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] d;
        logic        me;
        int          lat;
        @(negedge clk);
        dut.Mem[8] = 8'h00; dut.Mem[11] = 8'h00;
        xact(1'b0, 2'b00, 8'd9, 32'h1234567F, d, me, lat);
        n_tests++;
        if (lat !== WS + 1 || d !== 32'hE3A01005 || me !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_write: lat=%0d dout=%h merr=%b want %0d E3A01005 0",
                     lat, d, me, WS + 1);
        end
        xact(1'b0, 2'b01, 8'd10, 32'h9999BEEF, d, me, lat);
        n_tests++;
        if (lat !== WS + 1 || d !== 32'hE3A01005) begin
            n_fail++;
            $display("FAIL half_write: lat=%0d dout=%h want %0d E3A01005", lat, d, WS + 1);
        end
        xact(1'b1, 2'b10, 8'd8, 32'h0, d, me, lat);
        n_tests++;
        if (d !== 32'h007FBEEF || me !== 1'b0) begin
            n_fail++;
            $display("FAIL word_read_8: dout=%h merr=%b want 007FBEEF 0", d, me);
        end
        xact(1'b1, 2'b01, 8'd10, 32'h0, d, me, lat);
        n_tests++;
        if (d !== 32'h0000BEEF) begin
            n_fail++;
            $display("FAIL half_read_10: dout=%h want 0000BEEF", d);
        end
        xact(1'b1, 2'b00, 8'd9, 32'h0, d, me, lat);
        n_tests++;
        if (d !== 32'h0000007F) begin
            n_fail++;
            $display("FAIL byte_read_9: dout=%h want 0000007F", d);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic        me;
        int          lat;
        logic [31:0] exp_d;
        logic        exp_me;
        logic [15:0] exp_mem;
`ifdef RAM_ALIGN_CHECK_EN
        exp_d = 32'h0; exp_me = 1'b1; exp_mem = 16'h3456;
`else
        exp_d = 32'h12345678; exp_me = 1'b0; exp_mem = 16'hABCD;
`endif
        @(negedge clk);
        dut.Mem[8'hFE] = 8'h12; dut.Mem[8'hFF] = 8'h34;
        dut.Mem[8'h00] = 8'h56; dut.Mem[8'h01] = 8'h78;
        xact(1'b1, 2'b10, 8'hFE, 32'h0, d, me, lat);
        n_tests++;
        if (d !== exp_d || me !== exp_me || lat !== WS + 1) begin
            n_fail++;
            $display("FAIL wrap_word_read: dout=%h merr=%b lat=%0d want %h %b %0d",
                     d, me, lat, exp_d, exp_me, WS + 1);
        end
        xact(1'b0, 2'b01, 8'hFF, 32'h0000ABCD, d, me, lat);
        n_tests++;
        if ({dut.Mem[8'hFF], dut.Mem[8'h00]} !== exp_mem || me !== exp_me) begin
            n_fail++;
            $display("FAIL wrap_half_write: mem=%h merr=%b want %h %b",
                     {dut.Mem[8'hFF], dut.Mem[8'h00]}, me, exp_mem, exp_me);
        end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        logic        me;
        int          lat;
        logic        seen;
        @(negedge clk);
        dut.Mem[4] = 8'h11; dut.Mem[5] = 8'h22; dut.Mem[6] = 8'h33; dut.Mem[7] = 8'h44;
        mfa = 1'b1; rw_ram = 1'b0; typ = 2'b10; addr = 8'd4; data_in = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk); mfa = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (mfc !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_mfc: mfc rose=%b want 0", seen);
        end
        xact(1'b1, 2'b10, 8'd4, 32'h0, d, me, lat);
        n_tests++;
        if (d !== 32'h11223344 || lat !== WS + 1) begin
            n_fail++;
            $display("FAIL abort_mem: dout=%h lat=%0d want 11223344 %0d", d, lat, WS + 1);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] d;
        logic        me;
        int          lat;
        @(negedge clk);
        mfa = 1'b1; rw_ram = 1'b0; typ = 2'b10; addr = 8'd8; data_in = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk); #2;
        clr = 1'b0;
        #1;
        n_tests++;
        if (mfc !== 1'b0 || data_out !== 32'h0 || merr !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: mfc=%b dout=%h merr=%b want 0 0 0", mfc, data_out, merr);
        end
        @(negedge clk); mfa = 1'b0;
        @(negedge clk); clr = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (mfc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: mfc=%b want 0", mfc);
        end
        xact(1'b1, 2'b10, 8'd8, 32'h0, d, me, lat);
        n_tests++;
        if (d !== 32'h007FBEEF || lat !== WS + 1) begin
            n_fail++;
            $display("FAIL reset_mem: dout=%h lat=%0d want 007FBEEF %0d", d, lat, WS + 1);
        end
    endtask

    task automatic test_reserved_type();
        logic [31:0] d;
        logic        me;
        int          lat;
        logic        bad;
        @(negedge clk);
        mfa = 1'b1; rw_ram = 1'b1; typ = 2'b11; addr = 8'd0;
        lat = -1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (mfc) begin
                lat = i;
                break;
            end
        end
        n_tests++;
        if (lat !== WS + 1 || merr !== 1'b1 || data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL type11_read: lat=%0d merr=%b dout=%h want %0d 1 0",
                     lat, merr, data_out, WS + 1);
        end
        bad = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (mfc !== 1'b1 || merr !== 1'b1 || data_out !== 32'h0) bad = 1'b1;
        end
        n_tests++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL type11_hold: glitch=%b want 0", bad);
        end
        @(negedge clk); mfa = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (mfc !== 1'b0) begin
            n_fail++;
            $display("FAIL type11_drop: mfc=%b want 0", mfc);
        end
        xact(1'b0, 2'b11, 8'd4, 32'hFFFFFFFF, d, me, lat);
        n_tests++;
        if (me !== 1'b1 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL type11_write: merr=%b dout=%h want 1 0", me, d);
        end
        xact(1'b1, 2'b10, 8'd4, 32'h0, d, me, lat);
        n_tests++;
        if (d !== 32'h11223344 || me !== 1'b0) begin
            n_fail++;
            $display("FAIL type11_nowrite: dout=%h merr=%b want 11223344 0", d, me);
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_half();
        test_wrap();
        test_abort();
        test_reset_mid_op();
        test_reserved_type();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the data path's MFA/MFC memory handshake; it is the slave end of the interface the control unit drives.
- Holds a byte-addressable, big-endian RAM (Mem[a] is the most significant byte of a word at a).
- Serves byte, halfword and word reads and writes after a programmable number of wait states, and signals completion on MFC.

Parameters:
- ADDR_W, 8, address width; the memory holds 2**ADDR_W bytes.
- WAIT_STATES, 2, extra cycles between request accept and MFC; 0 is legal.

Ports:
- CLK  in  1  rising-edge clock
- CLR  in  1  asynchronous, active-low reset
- MFA  in  1  memory function activate; held high for the whole transaction
- RW_RAM  in  1  1 = read, 0 = write
- TYPE  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved
- ADDR  in  ADDR_W  byte address
- DATA_IN  in  32  write data, right-justified for byte and halfword
- DATA_OUT  out  32  read data
- MFC  out  1  memory function complete
- MERR  out  1  access error, qualified by MFC

Behaviour:
- Reset: CLR low forces state IDLE, MFC=0, MERR=0, DATA_OUT=0 and the wait counter to 0, immediately and asynchronously. Memory contents are not cleared. Reset mid-transaction aborts it, and no write occurs.
- State IDLE: on an edge with MFA=1, latch RW_RAM, TYPE, ADDR and DATA_IN, load cnt=WAIT_STATES, go to WAIT.
- State WAIT: on each edge, if MFA=0, abort to IDLE with no memory change. Else if cnt!=0, decrement cnt. Else go to DONE and perform the access on that same edge.
- State DONE: MFC=1, with DATA_OUT and MERR registered and stable. The state holds while MFA=1. On an edge with MFA=0, go to IDLE with MFC=0 and DATA_OUT held at its last value.
- Handshake is return-to-zero: a new request is accepted only from IDLE, so MFA must be seen low at least one edge after MFC.
- Latency: with the accept edge at e0, MFC is high after edge e0+WAIT_STATES+1.
- Byte access (TYPE 00):
  - Read: DATA_OUT={24'b0, Mem[A]}.
  - Write: Mem[A]=DATA_IN[7:0].
- Halfword access (TYPE 01):
  - Read: DATA_OUT={16'b0, Mem[A], Mem[A+1]}.
  - Write: Mem[A]=DATA_IN[15:8], Mem[A+1]=DATA_IN[7:0].
- Word access (TYPE 10):
  - Read: DATA_OUT={Mem[A], Mem[A+1], Mem[A+2], Mem[A+3]}.
  - Write is the same byte mapping.
- Byte addresses A+k wrap modulo 2**ADDR_W.
- TYPE 11: the transaction completes normally with MFC=1 and MERR=1. No write occurs and DATA_OUT=0.
- A write never changes DATA_OUT; it keeps its previous value.
- Latched request fields are used throughout the transaction; input changes after accept are ignored.
- Memory is backdoor-loadable by hierarchical reference to array Mem (bytes, index 0..2**ADDR_W-1).

Optional Feature:
- Macro: RAM_ALIGN_CHECK_EN.
- Defined:
  - Halfword with A[0]!=0, or word with A[1:0]!=0, completes with MFC=1 and MERR=1.
  - No write occurs; DATA_OUT=0.
- Undefined:
  - Misaligned accesses proceed using the byte mapping above, with wrap.
  - MERR rises only for TYPE 11.

Test Plan:
1. Word read, WAIT_STATES=2: Mem[0..3]=E3,A0,10,05; MFA=1, RW_RAM=1, TYPE=10, ADDR=0 at e0 -> MFC=0 after e0..e2, MFC=1 after e3, DATA_OUT=32'hE3A01005, MERR=0. Drop MFA -> MFC=0 after the next edge.
2. Byte/halfword write then word read at ADDR=8:
   - Write byte 8'h7F to address 9.
   - Write halfword 16'hBEEF to address 10.
   - Read word at 8 -> 32'h007FBEEF, with Mem[8] initialised to 0.
   - Halfword read at 10 -> 32'h0000BEEF.
3. Wrap: Mem[FE..FF]=12,34 and Mem[00..01]=56,78; word read at 8'hFE without the macro -> 32'h12345678, MERR=0. With RAM_ALIGN_CHECK_EN -> MERR=1 and DATA_OUT=0.
4. Abort: word write of 32'hDEADBEEF to address 4 with MFA dropped one cycle after accept -> MFC never rises and Mem[4..7] is unchanged. The next request is accepted normally.
5. Reset mid-op: CLR=0 during WAIT -> MFC=0 and DATA_OUT=0 immediately, without waiting for a clock edge. After release with MFA=0, state is IDLE and a subsequent read returns the pre-reset memory contents.
6. TYPE=11 read at address 0 -> MFC=1, MERR=1, DATA_OUT=0. MFA held high for 5 cycles -> MFC stays high and no second transaction occurs.
